// File: rtl/muldiv_seq_ctrl.sv
// Multi-cycle unsigned MULTU/DIVU sequencer for the HI/LO unit.
// Shares one external 32-bit add/sub unit across 32 shift-add / restoring-divide iterations.
module muldiv_seq_ctrl #(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      CNT_W   = 6,
  parameter logic [WIDTH-1:0] DZ_QUOT = WIDTH'(32'hFFFF_FFFF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             add_sub,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_res,
  input  logic             add_cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // Working registers: {w_hi, w_lo} is the product pair for MULTU and {R, Q} for DIVU.
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] b_q;
  logic             op_q;
  logic [CNT_W-1:0] cnt;

  logic             div0;
  logic             last;
  logic             take;
  logic [WIDTH-1:0] rem_shift;

  assign div0      = op && (opb == '0);
  assign last      = (cnt == CNT_W'(WIDTH - 1));
  assign rem_shift = {w_hi[WIDTH-2:0], w_lo[WIDTH-1]};
  // A set R[31] means the shifted remainder exceeds 32 bits, so the subtract always fits.
  assign take      = w_hi[WIDTH-1] | ~add_cout;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = div0 ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shared adder drive, idle (all zero) outside CALC
  always_comb begin
    add_sub = 1'b0;
    add_a   = '0;
    add_b   = '0;
    if (state == S_CALC) begin
      add_sub = op_q;
      add_a   = op_q ? rem_shift : w_hi;
      add_b   = b_q;
    end
  end

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    w_hi_nxt = w_hi;
    w_lo_nxt = w_lo;
    if (op_q) begin
      w_hi_nxt = take ? add_res : rem_shift;
      w_lo_nxt = {w_lo[WIDTH-2:0], take};
    end else if (w_lo[0]) begin
      w_hi_nxt = {add_cout, add_res[WIDTH-1:1]};
      w_lo_nxt = {add_res[0], w_lo[WIDTH-1:1]};
    end else begin
      w_hi_nxt = {1'b0, w_hi[WIDTH-1:1]};
      w_lo_nxt = {w_hi[0], w_lo[WIDTH-1:1]};
    end
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      w_hi     <= '0;
      w_lo     <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      cnt      <= '0;
    end else begin
      busy <= (state_nxt == S_CALC);
      done <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q     <= op;
            cnt      <= '0;
            div_zero <= div0;
            w_hi     <= '0;
            b_q      <= op ? opb : opa;
            w_lo     <= op ? opa : opb;
            if (div0) begin
              hi <= opa;
              lo <= DZ_QUOT;
            end
          end
        end
        S_CALC: begin
          w_hi <= w_hi_nxt;
          w_lo <= w_lo_nxt;
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            hi <= w_hi_nxt;
            lo <= w_lo_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: behavioural adder, 64-bit arithmetic reference,
// directed corner cases and randomized MULTU/DIVU traffic.
module tb_muldiv_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        add_sub;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_res;
  logic        add_cout;

  int n_pass  = 0;
  int n_total = 0;

  muldiv_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .opa      (opa),
    .opb      (opb),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo),
    .add_sub  (add_sub),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_res  (add_res),
    .add_cout (add_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External add/sub unit: cout is carry for add, borrow (A < B) for sub
  always_comb begin
    if (add_sub) begin
      add_res  = add_a - add_b;
      add_cout = (add_a < add_b);
    end else begin
      {add_cout, add_res} = {1'b0, add_a} + {1'b0, add_b};
    end
  end

  // Reference: plain 64-bit arithmetic
  task automatic ref_model(input logic o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el, output logic ez);
    logic [63:0] prod;
    ez = 1'b0;
    if (o && b == 32'd0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
      ez = 1'b1;
    end else if (o) begin
      el = a / b;
      eh = a % b;
    end else begin
      prod = 64'(a) * 64'(b);
      eh   = prod[63:32];
      el   = prod[31:0];
    end
  endtask

  // Issue one operation from IDLE; returns results, done latency and busy-cycle count
  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ohi, output logic [31:0] olo, output logic odz,
                       output int lat, output int busy_cyc);
    @(posedge clk);
    @(negedge clk);
    op = o; opa = a; opb = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    opa = $urandom;
    opb = $urandom;
    op  = 1'($urandom_range(0, 1));
    lat = 1;
    busy_cyc = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cyc++;
      @(posedge clk);
      #1;
      lat++;
    end
    ohi = hi;
    olo = lo;
    odz = div_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({busy, done, div_zero, hi, lo, add_sub, add_a, add_b} !== '0) begin
      $display("FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h sub=%b a=%h b=%h, required all 0",
               busy, done, div_zero, hi, lo, add_sub, add_a, add_b);
    end else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu();
    logic [31:0] ta [5] = '{32'd7, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h1234_5678};
    logic [31:0] tb [5] = '{32'd6, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h9ABC_DEF0};
    logic [31:0] rh, rl, eh, el;
    logic rz, ez;
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      do_op(1'b0, ta[i], tb[i], rh, rl, rz, lat, bc);
      ref_model(1'b0, ta[i], tb[i], eh, el, ez);
      n_total++;
      if ({rh, rl, rz} !== {eh, el, ez}) begin
        $display("FAIL multu_%0d: %h x %h got hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b",
                 i, ta[i], tb[i], rh, rl, rz, eh, el, ez);
      end else n_pass++;
      n_total++;
      if (lat !== 33 || bc !== 32) begin
        $display("FAIL multu_timing_%0d: done at cycle %0d busy %0d cycles, required 33 and 32", i, lat, bc);
      end else n_pass++;
    end
    @(posedge clk);
    #1;
    n_total++;
    if ({done, busy, add_sub, add_a, add_b} !== '0) begin
      $display("FAIL idle_after_done: done=%b busy=%b sub=%b a=%h b=%h, required all 0",
               done, busy, add_sub, add_a, add_b);
    end else n_pass++;
  endtask

  task automatic test_divu();
    logic [31:0] ta [5] = '{32'd100, 32'h8000_0001, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF};
    logic [31:0] tb [5] = '{32'd7, 32'd3, 32'd1, 32'd9, 32'h8000_0000};
    logic [31:0] rh, rl, eh, el;
    logic rz, ez;
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      do_op(1'b1, ta[i], tb[i], rh, rl, rz, lat, bc);
      ref_model(1'b1, ta[i], tb[i], eh, el, ez);
      n_total++;
      if ({rh, rl, rz} !== {eh, el, ez}) begin
        $display("FAIL divu_%0d: %h / %h got hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b",
                 i, ta[i], tb[i], rh, rl, rz, eh, el, ez);
      end else n_pass++;
      n_total++;
      if (lat !== 33 || bc !== 32) begin
        $display("FAIL divu_timing_%0d: done at cycle %0d busy %0d cycles, required 33 and 32", i, lat, bc);
      end else n_pass++;
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] rh, rl;
    logic rz;
    int lat, bc;
    @(posedge clk);
    @(negedge clk);
    op = 1'b1; opa = 32'd1234; opb = 32'd0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_total++;
    if ({done, busy, div_zero, hi, lo} !== {1'b1, 1'b0, 1'b1, 32'd1234, 32'hFFFF_FFFF}) begin
      $display("FAIL div_zero: done=%b busy=%b dz=%b hi=%h lo=%h, required 1 0 1 000004d2 ffffffff",
               done, busy, div_zero, hi, lo);
    end else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if ({done, busy, div_zero, hi} !== {1'b0, 1'b0, 1'b1, 32'd1234}) begin
      $display("FAIL div_zero_after: done=%b busy=%b dz=%b hi=%h, required 0 0 1 000004d2",
               done, busy, div_zero, hi);
    end else n_pass++;
    do_op(1'b0, 32'd3, 32'd3, rh, rl, rz, lat, bc);
    n_total++;
    if ({rz, rl} !== {1'b0, 32'd9}) begin
      $display("FAIL div_zero_clear: dz=%b lo=%h, required 0 00000009", rz, rl);
    end else n_pass++;
  endtask

  task automatic test_ignore_and_reset();
    logic [31:0] rh, rl;
    logic rz;
    int lat, bc, done_seen;
    @(posedge clk);
    @(negedge clk);
    op = 1'b0; opa = 32'd5; opb = 32'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == 10) begin
        @(negedge clk);
        start = 1'b1; op = 1'b1; opa = 32'hDEAD_BEEF; opb = 32'd0;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    n_total++;
    if ({hi, lo, div_zero} !== {32'd0, 32'd25, 1'b0} || lat !== 33) begin
      $display("FAIL ignore_start: hi=%h lo=%h dz=%b done at %0d, required 0 00000019 0 at 33",
               hi, lo, div_zero, lat);
    end else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (busy !== 1'b0) begin
      $display("FAIL ignore_start_no_queue: busy=%b, required 0", busy);
    end else n_pass++;

    @(negedge clk);
    op = 1'b0; opa = 32'd9; opb = 32'd9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, div_zero, hi, lo, add_sub, add_a, add_b} !== '0) begin
      $display("FAIL reset_mid_calc: busy=%b done=%b dz=%b hi=%h lo=%h sub=%b a=%h b=%h, required all 0",
               busy, done, div_zero, hi, lo, add_sub, add_a, add_b);
    end else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    n_total++;
    if (done_seen !== 0) begin
      $display("FAIL reset_abort: done/busy seen %0d cycles after reset, required 0", done_seen);
    end else n_pass++;
    do_op(1'b0, 32'd3, 32'd4, rh, rl, rz, lat, bc);
    n_total++;
    if ({rh, rl, rz} !== {32'd0, 32'd12, 1'b0} || lat !== 33) begin
      $display("FAIL post_reset_op: hi=%h lo=%h dz=%b done at %0d, required 0 0000000c 0 at 33",
               rh, rl, rz, lat);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rh, rl;
    logic rz;
    int lat, bc;
    do_op(1'b0, 32'd11, 32'd13, rh, rl, rz, lat, bc);
    start = 1'b1; op = 1'b1; opa = 32'd1000; opb = 32'd10;
    @(posedge clk);
    #1;
    n_total++;
    if (busy !== 1'b0) begin
      $display("FAIL start_with_done: busy=%b, required 0", busy);
    end else n_pass++;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1) begin
      $display("FAIL start_next_idle: busy=%b, required 1", busy);
    end else n_pass++;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_total++;
    if ({hi, lo} !== {32'd0, 32'd100} || lat !== 33) begin
      $display("FAIL back_to_back: hi=%h lo=%h done at %0d, required 0 00000064 at 33", hi, lo, lat);
    end else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] a, b, rh, rl, eh, el;
    logic o, rz, ez;
    int lat, bc, kind, exp_lat;
    for (int i = 0; i < 1000; i++) begin
      o    = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 6);
      a    = $urandom;
      b    = $urandom;
      case (kind)
        0: b = 32'd1;
        1: a = 32'd0;
        2: begin a = $urandom_range(0, 1000); b = a + 32'($urandom_range(1, 1000)); end
        3: b = 32'd0;
        4: begin a = $urandom_range(0, 255); b = $urandom_range(1, 255); end
        default: ;
      endcase
      do_op(o, a, b, rh, rl, rz, lat, bc);
      ref_model(o, a, b, eh, el, ez);
      exp_lat = (o && b == 32'd0) ? 1 : 33;
      n_total++;
      if ({rh, rl, rz} !== {eh, el, ez}) begin
        $display("FAIL random_%0d: op=%b %h,%h got hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b",
                 i, o, a, b, rh, rl, rz, eh, el, ez);
      end else n_pass++;
      n_total++;
      if (lat !== exp_lat) begin
        $display("FAIL random_latency_%0d: op=%b done at %0d, required %0d", i, o, lat, exp_lat);
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_divu();
    test_div_zero();
    test_ignore_and_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
